serial_word_feeder: RTL and testbench

Parallel-to-serial front end for the bit-serial two's-complement stage. Accepts WIDTH-bit words over a valid/ready handshake and emits each word LSB-first, one bit per clock. Each word is preceded by a one-cycle frame_reset pulse that clears the complementer's "first 1 seen" state, so every word is complemented independently. A one-entry holding buffer lets the next word be accepted while the current word is shifting, sustaining one word per WIDTH+1 cycles.

---
 rtl/feeder_pkg.sv | 10 +
 rtl/word_hold_buffer.sv | 40 ++++
 rtl/serial_word_feeder.sv | 100 ++++++++++
 tb/tb_serial_word_feeder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// Shared definitions for the serial word feeder: FSM encoding and default word width.
package feeder_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01,
    SHIFT = 2'b10
  } state_e;
endpackage

// File: rtl/word_hold_buffer.sv
// One-entry holding register that parks the next word while the current one shifts out.
module word_hold_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fill_i,
  input  logic             drain_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             full_q, full_d;

  // Fill only happens while empty and drain only while full, so they never collide.
  always_comb begin
    buf_d  = buf_q;
    full_d = full_q;
    if (fill_i) begin
      buf_d  = data_i;
      full_d = 1'b1;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q  <= '0;
      full_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      full_q <= full_d;
    end
  end

  assign data_o = buf_q;
  assign full_o = full_q;
endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end: frame_reset pulse, then WIDTH bits LSB-first per word.
module serial_word_feeder
  import feeder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             load_ready_o,
  output logic             frame_reset_o,
  output logic             bit_out_o,
  output logic             bit_valid_o,
  output logic             word_last_o
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             buf_full, buf_fill, buf_drain;
  logic [WIDTH-1:0] buf_data;
  logic             accept, last_bit;

  assign load_ready_o = rst_ni & ~buf_full;
  assign accept       = load_valid_i & load_ready_o;
  assign last_bit     = (state_q == SHIFT) && (cnt_q == CNT_LAST);

  word_hold_buffer #(.WIDTH(WIDTH)) u_hold (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .fill_i  (buf_fill),
    .drain_i (buf_drain),
    .data_i  (load_data_i),
    .data_o  (buf_data),
    .full_o  (buf_full)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    buf_fill  = 1'b0;
    buf_drain = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = load_data_i;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d  = SHIFT;
        buf_fill = accept;
      end
      SHIFT: begin
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // Buffered word wins; otherwise a word offered right now skips the buffer.
          cnt_d = '0;
          if (buf_full) begin
            buf_drain = 1'b1;
            shreg_d   = buf_data;
            state_d   = CLEAR;
          end else if (accept) begin
            shreg_d = load_data_i;
            state_d = CLEAR;
          end else begin
            state_d = IDLE;
          end
        end else begin
          buf_fill = accept;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign frame_reset_o = (state_q == CLEAR);
  assign bit_valid_o   = (state_q == SHIFT);
  assign bit_out_o     = (state_q == SHIFT) & shreg_q[0];
  assign word_last_o   = last_bit;
endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: directed scenarios plus random traffic against a timeline model.
module tb_serial_word_feeder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_ready, frame_reset, bit_out, bit_valid, word_last;

  serial_word_feeder #(.WIDTH(W)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .load_valid_i  (load_valid),
    .load_data_i   (load_data),
    .load_ready_o  (load_ready),
    .frame_reset_o (frame_reset),
    .bit_out_o     (bit_out),
    .bit_valid_o   (bit_valid),
    .word_last_o   (word_last)
  );

  always #5 clk = ~clk;

  // Model: each accepted word owns a frame cycle f; its bits occupy f+1..f+W.
  typedef struct {
    int           e;
    int           f;
    logic [W-1:0] d;
  } word_t;

  word_t words[$];
  int    cur = 0;
  int    last_end = -100;
  bit    in_rst = 1'b1;
  int    checks = 0;
  int    failures = 0;

  logic [W-1:0] cacc;
  int           cidx;
  bit           seen;

  function automatic bit mdl_ready(int c);
    if (in_rst) return 1'b0;
    foreach (words[i]) if (words[i].e <= c && c < words[i].f) return 1'b0;
    return 1'b1;
  endfunction

  // {load_ready, frame_reset, bit_valid, bit_out, word_last}
  function automatic logic [4:0] mdl_out(int c);
    logic fr = 1'b0, bv = 1'b0, bo = 1'b0, wl = 1'b0;
    if (in_rst) return 5'b0;
    foreach (words[i]) begin
      if (words[i].f == c) fr = 1'b1;
      if (c > words[i].f && c <= words[i].f + W) begin
        bv = 1'b1;
        bo = words[i].d[c - words[i].f - 1];
        wl = (c == words[i].f + W);
      end
    end
    return {mdl_ready(c), fr, bv, bo, wl};
  endfunction

  task automatic check_cycle();
    logic [4:0]   obs, exp;
    logic [W-1:0] want;
    bit           found;
    obs = {load_ready, frame_reset, bit_valid, bit_out, word_last};
    exp = mdl_out(cur);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL outputs cycle=%0d rdy/fr/bv/bo/wl got=%b exp=%b", cur, obs, exp);
    end
    // Downstream two's-complementer fed by this stream: each word must come out negated.
    if (frame_reset === 1'b1) begin
      seen = 1'b0; cidx = 0; cacc = '0;
    end
    if (bit_valid === 1'b1) begin
      if (cidx < W) cacc[cidx] = seen ? ~bit_out : bit_out;
      seen = seen | bit_out;
      cidx++;
    end
    if (word_last === 1'b1) begin
      found = 1'b0;
      want  = '0;
      foreach (words[i]) if (words[i].f + W == cur) begin
        found = 1'b1;
        want  = ~words[i].d + W'(1);
      end
      if (found) begin
        checks++;
        assert (cacc === want) else begin
          failures++;
          $error("FAIL complement cycle=%0d got=%h exp=%h", cur, cacc, want);
        end
      end
    end
    while (words.size() > 0 && words[0].f + W < cur) void'(words.pop_front());
  endtask

  task automatic step(input bit v, input logic [W-1:0] d);
    bit acc;
    int f;
    load_valid = v;
    load_data  = d;
    acc = v && !in_rst && mdl_ready(cur);
    @(posedge clk);
    cur++;
    if (acc) begin
      f = (cur > last_end + 1) ? cur : last_end + 1;
      words.push_back('{cur, f, d});
      last_end = f + W;
    end
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, W'($urandom));
  endtask

  task automatic offer(input logic [W-1:0] d);
    bit done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      done = !in_rst && mdl_ready(cur);
      step(1'b1, d);
    end
    if (!done) begin
      failures++;
      $display("FAIL offer_timeout word=%h got=not_accepted exp=accepted", d);
    end
  endtask

  task automatic reset_pulse(input int n_low, input bit v);
    rst_n = 1'b0;
    in_rst = 1'b1;
    words.delete();
    last_end = -100;
    #1 check_cycle();
    repeat (n_low) step(v, W'($urandom));
    rst_n = 1'b1;
    in_rst = 1'b0;
    #1 check_cycle();
  endtask

  initial begin
    @(negedge clk);
    check_cycle();
    repeat (2) step(1'b1, W'($urandom));
    rst_n = 1'b1;
    in_rst = 1'b0;
    #1 check_cycle();

    // Single word, then a second word to confirm complementer state clears.
    offer(8'hB4); idle(12);
    offer(8'h01); idle(12);

    // Back-to-back with valid held.
    offer(8'hA5); offer(8'h3C); offer(8'h5A); idle(30);

    // Direct handoff on the last-bit edge.
    offer(8'hC3);
    while (cur < last_end) step(1'b0, 8'h00);
    step(1'b1, 8'hFF);
    idle(12);

    // Reset during bit 3 with a buffered word.
    offer(8'h11); offer(8'h22);
    while (cur < words[0].f + 4) step(1'b0, 8'h00);
    reset_pulse(3, 1'b0);
    idle(12);

    // Reset held while upstream offers a word.
    reset_pulse(4, 1'b1);
    offer(8'h9E); idle(12);

    // Random traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) reset_pulse($urandom_range(1, 3), 1'($urandom));
      step($urandom_range(0, 2) != 0, W'($urandom));
    end
    idle(15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
